letter_scan_driver: RTL and testbench

- Consumes the four 4-bit letter codes from the day-name generator and drives a common-anode 4-digit 7-segment display through time-multiplexed scanning.
- Snapshots the letter codes once per frame so a word never tears mid-scan.
- Decodes each letter code to a segment pattern and provides anti-ghosting blanking plus an optional blink.
- Sits directly downstream of the day-name stage and directly upstream of the board pins.

---
 rtl/letter_scan_driver_if.sv | 22 ++
 rtl/letter_scan_driver.sv | 115 +++++++++++
 tb/tb_letter_scan_driver.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/letter_scan_driver_if.sv
// Letter-code inputs and display-pin outputs of the scan driver.
// The master side supplies letters/blink and the slave side drives the display.
interface letter_scan_driver_if;
  logic [3:0] first_letter;
  logic [3:0] second_letter;
  logic [3:0] third_letter;
  logic [3:0] fourth_letter;
  logic       blink_en;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_tick;

  modport master (
    output first_letter, second_letter, third_letter, fourth_letter, blink_en,
    input  seg, an, frame_tick
  );

  modport slave (
    input  first_letter, second_letter, third_letter, fourth_letter, blink_en,
    output seg, an, frame_tick
  );
endinterface

// File: rtl/letter_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver for letter codes.
// Letters are snapshotted once per frame, decoded, blanked per slot and optionally blinked.
module letter_scan_driver #(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 2,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  letter_scan_driver_if.slave disp
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    digit;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic [3:0]    shadow [4];
  logic [6:0]    seg_q;
  logic [3:0]    an_q;
  logic          tick_q;

  logic          slot_end;
  logic          frame_end;
  logic          slot_open;
  logic [6:0]    seg_next;
  logic [3:0]    an_next;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'd0:    decode = 7'h00;
      4'd1:    decode = 7'h77;
      4'd2:    decode = 7'h5E;
      4'd3:    decode = 7'h79;
      4'd4:    decode = 7'h71;
      4'd5:    decode = 7'h76;
      4'd6:    decode = 7'h06;
      4'd7:    decode = 7'h54;
      4'd8:    decode = 7'h3F;
      4'd9:    decode = 7'h73;
      4'd10:   decode = 7'h50;
      4'd11:   decode = 7'h6D;
      4'd12:   decode = 7'h78;
      4'd13:   decode = 7'h3E;
      default: decode = 7'h40;
    endcase
  endfunction

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (digit == 2'd3);

  // With no blanking window the comparison would be trivially true, so skip it.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign slot_open = 1'b1;
    end else begin : g_blank
      assign slot_open = (cnt >= CW'(BLANK_CYCLES));
    end
  endgenerate

  always_comb begin
    an_next  = 4'b0000;
    seg_next = decode(shadow[digit]);
    if (slot_open && !(disp.blink_en && blink_phase)) begin
      an_next[digit] = 1'b1;
    end
  end

  // The shadow load, frame tick and blink counter all share the last cycle of a frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      digit       <= 2'd0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= 4'd0;
      end
      seg_q       <= 7'h00;
      an_q        <= 4'b0000;
      tick_q      <= 1'b0;
    end else begin
      cnt    <= slot_end ? '0 : cnt + CW'(1);
      tick_q <= frame_end;
      if (slot_end) begin
        digit <= digit + 2'd1;
      end
      if (frame_end) begin
        shadow[0] <= disp.first_letter;
        shadow[1] <= disp.second_letter;
        shadow[2] <= disp.third_letter;
        shadow[3] <= disp.fourth_letter;
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
      seg_q <= seg_next;
      an_q  <= an_next;
    end
  end

  assign disp.seg        = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign disp.an         = AN_ACTIVE_LOW ? ~an_q : an_q;
  assign disp.frame_tick = tick_q;

endmodule

// File: tb/tb_letter_scan_driver.sv
// Scoreboard bench for letter_scan_driver: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the display outputs.
module tb_letter_scan_driver;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       tick;
  } exp_t;

  localparam logic [27:0] W_SP  = 28'h0;
  localparam logic [27:0] W_TUE = {7'h00, 7'h79, 7'h3E, 7'h78};
  localparam logic [27:0] W_FRI = {7'h00, 7'h06, 7'h50, 7'h71};
  localparam logic [27:0] W_ERR = {7'h00, 7'h06, 7'h50, 7'h40};

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  letter_scan_driver_if lif ();

  letter_scan_driver #(
    .SCAN_DIV      (4),
    .BLANK_CYCLES  (1),
    .BLINK_FRAMES  (2),
    .SEG_ACTIVE_LOW(1'b0),
    .AN_ACTIVE_LOW (1'b0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .disp (lif.slave)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] l0, input logic [3:0] l1,
                                input logic [3:0] l2, input logic [3:0] l3);
    lif.first_letter  = l0;
    lif.second_letter = l1;
    lif.third_letter  = l2;
    lif.fourth_letter = l3;
  endtask

  task automatic push_zero();
    exp_t e;
    e.an   = 4'b0000;
    e.seg  = 7'h00;
    e.tick = 1'b0;
    exp_q.push_back(e);
  endtask

  // Anodes light from the second cycle of each slot once k reaches vis_from.
  task automatic push_frame(input logic [27:0] word, input int vis_from, input int ncyc);
    exp_t e;
    int   d;
    for (int k = 0; k < ncyc; k++) begin
      d      = k / 4;
      e.seg  = word[d*7 +: 7];
      e.an   = (k >= vis_from && (k % 4) >= 1) ? 4'(1 << d) : 4'b0000;
      e.tick = (k == 15);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_output(input string name, input logic [6:0] got, input logic [6:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_output("an", {3'b000, lif.an}, {3'b000, e.an});
      check_output("seg", lif.seg, e.seg);
      check_output("frame_tick", {6'd0, lif.frame_tick}, {6'd0, e.tick});
    end
  end

  initial begin
    int n;
    rst_n        = 1'b0;
    lif.blink_en = 1'b0;
    apply_stimulus(4'd11, 4'd13, 4'd7, 4'd0);
    repeat (5) begin
      step(1);
      push_zero();
    end
    rst_n = 1'b1;
    apply_stimulus(4'd12, 4'd13, 4'd3, 4'd0);
    push_frame(W_SP, 0, 16);
    push_frame(W_TUE, 0, 16);
    push_frame(W_FRI, 0, 16);
    push_frame(W_ERR, 0, 16);
    push_frame(W_ERR, 0, 9);
    step(22);
    apply_stimulus(4'd4, 4'd10, 4'd6, 4'd0);
    step(18);
    lif.first_letter = 4'hE;
    step(33);
    rst_n = 1'b0;
    push_zero();
    step(1);
    rst_n = 1'b1;
    push_frame(W_SP, 0, 16);
    push_frame(W_ERR, 0, 16);
    step(32);
    rst_n = 1'b0;
    push_zero();
    push_zero();
    step(2);
    rst_n        = 1'b1;
    lif.blink_en = 1'b1;
    push_frame(W_SP, 0, 16);
    push_frame(W_ERR, 0, 16);
    push_frame(W_ERR, 6, 16);
    push_frame(W_ERR, 0, 16);
    push_frame(W_ERR, 0, 16);
    push_frame(W_ERR, 0, 16);
    push_frame(W_ERR, 16, 16);
    step(38);
    lif.blink_en = 1'b0;
    step(28);
    lif.blink_en = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
